// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with a valid-qualified instruction and data-read interface.
// Latency: one instruction per clock edge; an M-reading instruction waits in WAIT until inM_valid.
// Backpressure: stall is high whenever nothing executes; instruction must stay stable while in WAIT.
module hack_cpu_mc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  inM,
  input  logic              inM_valid,
  output logic [WIDTH-1:0]  outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [PC_W-1:0]   pc,
  output logic              stall,
  output logic [31:0]       retired
);

  typedef enum logic {
    EXEC = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       retired_q, retired_d;

  // Instruction fields; bits [WIDTH-2:13] of a C-instruction carry no meaning.
  logic       is_c;
  logic       sel_m;
  logic       zx, nx, zy, ny, fn, no;
  logic [2:0] dest;
  logic [2:0] jump;

  assign is_c  = instruction[WIDTH-1];
  assign sel_m = instruction[12];
  assign zx    = instruction[11];
  assign nx    = instruction[10];
  assign zy    = instruction[9];
  assign ny    = instruction[8];
  assign fn    = instruction[7];
  assign no    = instruction[6];
  assign dest  = instruction[5:3];
  assign jump  = instruction[2:0];

  logic [WIDTH-1:0] alu_x, alu_y, alu_y_src, alu_raw, alu_out;
  logic             alu_zr, alu_ng, jump_ok;

  // Hack ALU: x is D, y is A or inM; zero/negate each input, add or AND, optionally negate result.
  always_comb begin
    alu_y_src = sel_m ? inM : a_q;
    alu_x     = zx ? '0 : d_q;
    alu_x     = nx ? ~alu_x : alu_x;
    alu_y     = zy ? '0 : alu_y_src;
    alu_y     = ny ? ~alu_y : alu_y;
    alu_raw   = fn ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out   = no ? ~alu_raw : alu_raw;
    alu_zr    = (alu_out == '0);
    alu_ng    = alu_out[WIDTH-1];
    jump_ok   = (jump[2] & alu_ng) | (jump[1] & alu_zr) | (jump[0] & ~alu_ng & ~alu_zr);
  end

  logic execute;

  // Decide whether the presented instruction retires this cycle; reset suppresses everything.
  always_comb begin
    execute = 1'b0;
    state_d = state_q;
    if (!reset) begin
      case (state_q)
        EXEC: begin
          if (instr_valid) begin
            if (!is_c || !sel_m || inM_valid) begin
              execute = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (inM_valid) begin
            execute = 1'b1;
            state_d = EXEC;
          end
        end
        default: state_d = EXEC;
      endcase
    end
  end

  // Architectural next state: registers move only on an executing cycle, jumps use pre-update A.
  always_comb begin
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    if (execute) begin
      if (!is_c) begin
        a_d = {1'b0, instruction[WIDTH-2:0]};
      end else begin
        if (dest[2]) a_d = alu_out;
        if (dest[1]) d_d = alu_out;
      end
      if (is_c && jump_ok) begin
        pc_d = a_q[PC_W-1:0];
      end else begin
        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
      retired_d = retired_q + 32'd1;
    end
  end

  // All state, FSM included, with asynchronous reset that also abandons a pending WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EXEC;
      a_q       <= '0;
      d_q       <= '0;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      d_q       <= d_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign outM     = alu_out;
  assign writeM   = execute & is_c & dest[0];
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;
  assign stall    = ~execute;
  assign retired  = retired_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
module tb_hack_cpu_mc;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] inM;
  logic        inM_valid;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;
  logic        stall;
  logic [31:0] retired;

  logic [31:0] i32;
  logic        v32;
  logic [31:0] m32;
  logic        mv32;
  logic [31:0] out32;
  logic        wr32;
  logic [30:0] addr32;
  logic [30:0] pc32;
  logic        stall32;
  logic [31:0] ret32;

  int checks;
  int errors;

  hack_cpu_mc #(.WIDTH(16), .ADDR_W(15), .PC_W(15)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .inM_valid(inM_valid), .outM(outM), .writeM(writeM),
    .addressM(addressM), .pc(pc), .stall(stall), .retired(retired)
  );

  hack_cpu_mc #(.WIDTH(32), .ADDR_W(31), .PC_W(31)) dut32 (
    .clk(clk), .reset(reset), .instruction(i32), .instr_valid(v32),
    .inM(m32), .inM_valid(mv32), .outM(out32), .writeM(wr32),
    .addressM(addr32), .pc(pc32), .stall(stall32), .retired(ret32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cinst(input logic a, input logic [5:0] c,
                                        input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [31:0] c32(input logic a, input logic [5:0] c,
                                      input logic [2:0] d, input logic [2:0] j);
    return {1'b1, 18'b0, a, c, d, j};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads D through the ALU by presenting "D" without a valid strobe, so nothing retires.
  task automatic peek_d(output logic [15:0] v);
    instruction = cinst(1'b0, 6'b001100, 3'b000, 3'b000);
    instr_valid = 1'b0;
    #1;
    v = outM;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction = cinst(1'b0, 6'b001100, 3'b001, 3'b000);
    instr_valid = 1'b1;
    inM = '0; inM_valid = 1'b0;
    i32 = '0; v32 = 1'b0; m32 = '0; mv32 = 1'b0;
    #1;
    checks++; if (pc !== 15'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM: got %b want 0", writeM); end
    tick();
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", stall); end
    checks++; if (addressM !== 15'd0) begin errors++; $display("FAIL reset_addressM: got %0d want 0", addressM); end
    instr_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL idle_stall: got %b want 1", stall); end
  endtask

  task automatic test_arith();
    logic [15:0] dv;
    instruction = 16'd12345; instr_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL first_exec_stall: got %b want 0", stall); end
    tick();
    checks++; if (addressM !== 15'd12345) begin errors++; $display("FAIL ainst_load: got %0d want 12345", addressM); end
    instruction = cinst(1'b0, 6'b110000, 3'b010, 3'b000);
    tick();
    instruction = 16'd23456;
    tick();
    instruction = cinst(1'b0, 6'b000111, 3'b110, 3'b000);
    #1;
    checks++; if (outM !== 16'd11111) begin errors++; $display("FAIL a_minus_d_out: got %0d want 11111", outM); end
    tick();
    checks++; if (pc !== 15'd4) begin errors++; $display("FAIL arith_pc: got %0d want 4", pc); end
    checks++; if (retired !== 32'd4) begin errors++; $display("FAIL arith_retired: got %0d want 4", retired); end
    checks++; if (addressM !== 15'd11111) begin errors++; $display("FAIL arith_A: got %0d want 11111", addressM); end
    peek_d(dv);
    checks++; if (dv !== 16'd11111) begin errors++; $display("FAIL arith_D: got %0d want 11111", dv); end
  endtask

  task automatic test_mwrite();
    instruction = 16'd1003; instr_valid = 1'b1;
    tick();
    instruction = cinst(1'b0, 6'b001100, 3'b001, 3'b000);
    #1;
    checks++; if (writeM !== 1'b1) begin errors++; $display("FAIL mwrite_strobe: got %b want 1", writeM); end
    checks++; if (addressM !== 15'd1003) begin errors++; $display("FAIL mwrite_addr: got %0d want 1003", addressM); end
    checks++; if (outM !== 16'd11111) begin errors++; $display("FAIL mwrite_data: got %0d want 11111", outM); end
    tick();
    checks++; if (pc !== 15'd6) begin errors++; $display("FAIL mwrite_pc: got %0d want 6", pc); end
    instr_valid = 1'b0;
    #1;
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL invalid_writeM: got %b want 0", writeM); end
  endtask

  task automatic test_mem_wait();
    logic [15:0] dv;
    instruction = 16'd1000; instr_valid = 1'b1;
    tick();
    instruction = cinst(1'b1, 6'b010011, 3'b010, 3'b000);
    inM = 16'd5; inM_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wait_enter_stall: got %b want 1", stall); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (stall !== 1'b1 || pc !== 15'd7) begin errors++; $display("FAIL wait_hold: stall %b pc %0d want 1 7", stall, pc); end
    end
    checks++; if (retired !== 32'd7) begin errors++; $display("FAIL wait_retired: got %0d want 7", retired); end
    inM_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wait_release_stall: got %b want 0", stall); end
    checks++; if (outM !== 16'd11106) begin errors++; $display("FAIL d_minus_m: got %0d want 11106", outM); end
    tick();
    inM_valid = 1'b0;
    checks++; if (pc !== 15'd8) begin errors++; $display("FAIL wait_pc: got %0d want 8", pc); end
    peek_d(dv);
    checks++; if (dv !== 16'd11106) begin errors++; $display("FAIL wait_D: got %0d want 11106", dv); end
  endtask

  task automatic test_jumps();
    instr_valid = 1'b1;
    instruction = cinst(1'b0, 6'b111010, 3'b010, 3'b000);
    tick();
    instruction = 16'd14;
    tick();
    instruction = cinst(1'b0, 6'b001100, 3'b000, 3'b100);
    tick();
    checks++; if (pc !== 15'd14) begin errors++; $display("FAIL jlt_taken: got %0d want 14", pc); end
    instruction = cinst(1'b0, 6'b101010, 3'b010, 3'b000);
    tick();
    checks++; if (pc !== 15'd15) begin errors++; $display("FAIL d_zero_pc: got %0d want 15", pc); end
    instruction = cinst(1'b0, 6'b001100, 3'b000, 3'b001);
    tick();
    checks++; if (pc !== 15'd16) begin errors++; $display("FAIL jgt_not_taken: got %0d want 16", pc); end
    instruction = cinst(1'b0, 6'b001100, 3'b000, 3'b010);
    tick();
    checks++; if (pc !== 15'd14) begin errors++; $display("FAIL jeq_taken: got %0d want 14", pc); end
    instruction = 16'h7FFF;
    tick();
    instruction = cinst(1'b0, 6'b101010, 3'b000, 3'b111);
    tick();
    checks++; if (pc !== 15'h7FFF) begin errors++; $display("FAIL jmp_max: got %0d want 32767", pc); end
    instruction = 16'd0;
    tick();
    checks++; if (pc !== 15'd0) begin errors++; $display("FAIL pc_wrap: got %0d want 0", pc); end
    checks++; if (retired !== 32'd17) begin errors++; $display("FAIL jumps_retired: got %0d want 17", retired); end
  endtask

  task automatic test_amd_jump();
    logic [15:0] dv;
    instruction = 16'd100; instr_valid = 1'b1;
    tick();
    instruction = cinst(1'b0, 6'b011111, 3'b111, 3'b111);
    #1;
    checks++; if (writeM !== 1'b1 || addressM !== 15'd100 || outM !== 16'd1) begin errors++; $display("FAIL amd_write: wr %b addr %0d out %0d want 1 100 1", writeM, addressM, outM); end
    tick();
    checks++; if (pc !== 15'd100) begin errors++; $display("FAIL amd_jump_pc: got %0d want 100", pc); end
    checks++; if (addressM !== 15'd1) begin errors++; $display("FAIL amd_newA: got %0d want 1", addressM); end
    peek_d(dv);
    checks++; if (dv !== 16'd1) begin errors++; $display("FAIL amd_newD: got %0d want 1", dv); end
  endtask

  task automatic test_reset_wait();
    instruction = cinst(1'b1, 6'b110111, 3'b001, 3'b000);
    instr_valid = 1'b1; inM = 16'd7; inM_valid = 1'b0;
    tick();
    checks++; if (stall !== 1'b1 || writeM !== 1'b0 || pc !== 15'd100) begin errors++; $display("FAIL rw_in_wait: stall %b wr %b pc %0d want 1 0 100", stall, writeM, pc); end
    reset = 1'b1; inM_valid = 1'b1;
    #1;
    checks++; if (pc !== 15'd0) begin errors++; $display("FAIL rw_pc: got %0d want 0", pc); end
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL rw_writeM: got %b want 0", writeM); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rw_retired: got %0d want 0", retired); end
    instruction = 16'd5; inM_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_exec_state: stall %b want 0", stall); end
    tick();
    checks++; if (pc !== 15'd1 || retired !== 32'd1 || addressM !== 15'd5) begin errors++; $display("FAIL rw_first_exec: pc %0d ret %0d addr %0d want 1 1 5", pc, retired, addressM); end
    instr_valid = 1'b0;
  endtask

  task automatic test_wide();
    i32 = 32'h7FFF_FFFF; v32 = 1'b1;
    tick();
    i32 = c32(1'b0, 6'b110000, 3'b010, 3'b000);
    tick();
    i32 = c32(1'b0, 6'b011111, 3'b010, 3'b000);
    tick();
    i32 = c32(1'b0, 6'b001100, 3'b000, 3'b100);
    #1;
    checks++; if (out32 !== 32'h8000_0000) begin errors++; $display("FAIL wide_D: got %h want 80000000", out32); end
    tick();
    checks++; if (pc32 !== 31'h7FFF_FFFF) begin errors++; $display("FAIL wide_jlt: got %h want 7fffffff", pc32); end
    checks++; if (ret32 !== 32'd4) begin errors++; $display("FAIL wide_retired: got %0d want 4", ret32); end
    v32 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_mwrite();
    test_mem_wait();
    test_jumps();
    test_amd_jump();
    test_reset_wait();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Parameters
REQ-001 SHALL provide parameter WIDTH, default 16, meaning data/instruction word width (legal values: 16 or greater).
REQ-002 SHALL provide parameter ADDR_W, default 15, meaning data address width (ADDR_W <= WIDTH-1).
REQ-003 SHALL provide parameter PC_W, default 15, meaning program counter width (PC_W <= WIDTH-1).

Interface
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port instruction, input, WIDTH bits: current instruction word.
REQ-007 SHALL have port instr_valid, input, 1 bit: instruction word is valid this cycle.
REQ-008 SHALL have port inM, input, WIDTH bits: data read from M[addressM].
REQ-009 SHALL have port inM_valid, input, 1 bit: inM is valid this cycle.
REQ-010 SHALL have port outM, output, WIDTH bits: ALU result, to be written to M.
REQ-011 SHALL have port writeM, output, 1 bit: write strobe for M.
REQ-012 SHALL have port addressM, output, ADDR_W bits: data address, equal to A[ADDR_W-1:0].
REQ-013 SHALL have port pc, output, PC_W bits: address of the next instruction.
REQ-014 SHALL have port stall, output, 1 bit: high in any cycle in which no instruction executes.
REQ-015 SHALL have port retired, output, 32 bits: count of executed instructions.

Function
REQ-016 SHALL treat an instruction with MSB=0 as an A-instruction: A <= zero-extended instruction[WIDTH-2:0].
REQ-017 SHALL treat an instruction with MSB=1 as a C-instruction with fields a=[12], comp=[11:6] (zx,nx,zy,ny,f,no), dest=[5:3] (A,D,M), jump=[2:0] (lt,eq,gt); bits [WIDTH-2:13] SHALL be ignored.
REQ-018 SHALL run the ALU at WIDTH bits: x=D; y=A when a=0, inM when a=1; f=1 selects add modulo 2^WIDTH, f=0 selects AND; zr and ng are derived from the ALU output.
REQ-019 SHALL use a 2-state FSM {EXEC, WAIT}.
REQ-020 In EXEC, an instruction SHALL execute when instr_valid=1 and (A-instruction, or a=0, or inM_valid=1).
REQ-021 In EXEC with instr_valid=1, a C-instruction with a=1 and inM_valid=0 SHALL move the FSM to WAIT and SHALL NOT execute.
REQ-022 In WAIT, the instruction SHALL execute and the FSM SHALL return to EXEC on the first cycle with inM_valid=1; instruction SHALL be held stable by the source while in WAIT.
REQ-023 When no instruction executes, A, D, pc, and retired SHALL hold, writeM SHALL be 0, and stall SHALL be 1.
REQ-024 writeM SHALL be combinational and equal to execute & C-instruction & dest[M].
REQ-025 outM SHALL be combinational from the ALU; addressM SHALL reflect A before the current instruction's update.
REQ-026 A, D, and pc SHALL update on the execute edge.
REQ-027 On execute, pc SHALL load A[PC_W-1:0] (pre-update A) when the jump condition holds, else pc SHALL load pc+1 modulo 2^PC_W, so 2^PC_W-1 wraps to 0.
REQ-028 A single instruction with dest=AMD and a taken jump SHALL write M at the old A, jump to the old A, and load new values into A and D.
REQ-029 retired SHALL increment by 1 per executed instruction and SHALL wrap from 2^32-1 to 0.

Reset
REQ-030 While reset=1, asynchronously: A=0, D=0, pc=0, retired=0, FSM=EXEC, writeM=0.
REQ-031 Reset asserted in WAIT SHALL abandon the pending instruction; no M write SHALL occur.
REQ-032 After reset deasserts, the first instruction SHALL execute on the first qualifying edge.

Verification
REQ-033 Arithmetic (WIDTH=16): @12345, D=A, @23456, AD=A-D, all with instr_valid=1 -> after 4 edges A=11111, D=11111, pc=4, retired=4.
REQ-034 M write: following REQ-033, @1003 then M=D -> during the M=D cycle writeM=1, addressM=1003, outM=11111; after that edge pc=6.
REQ-035 Memory wait: @1000, then D=D-M with inM_valid=0 for 3 cycles -> stall=1, pc and D hold, FSM=WAIT; then inM=5 with inM_valid=1, D=11111 -> D=11106, pc advances by 1.
REQ-036 Jumps: D=-1, @14, D;JLT -> pc=14; then D=0, D;JGT -> pc=previous+1; then D;JEQ -> jump taken; pc=2^15-1 with a non-jumping instruction -> pc=0.
REQ-037 Reset mid-WAIT: reset pulsed while FSM=WAIT -> pc=0 and writeM=0 immediately (before the next clock edge), retired=0, FSM=EXEC.
REQ-038 WIDTH=32, PC_W=ADDR_W=31: @2^31-1, D=A, D=D+1 -> D=0x80000000, ng=1, so D;JLT is taken.
